// File: rtl/calc_cmd_issuer.sv
// Command issuer: queues keypad commands and replays each one to the ALU as a timed Perform strobe.
// Latency (defaults): accept at edge N -> OP/K after N+1, Perform N+2..N+3, Result/ResultValid after N+5.
// Backpressure: CmdReady = !full; CALC_ISSUER_STATUS_EN adds Level and sticky DropErr outputs.

module calc_cmd_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    output logic          push_rdy,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   level
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         empty;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign push_rdy = !full;
    assign do_push  = push_vld && !full;
    assign do_pop   = pop && !empty;
    assign pop_dat  = mem[rd_ptr[AW-1:0]];
    assign level    = wr_ptr - rd_ptr;

    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

module calc_cmd_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       CmdValid,
    output logic       CmdReady,
    input  logic [2:0] CmdOP,
    input  logic [1:0] CmdK,
    input  logic       CmdClr,
    output logic       Perform,
    output logic [2:0] OP,
    output logic [1:0] K,
    output logic       Clr,
    input  logic [4:0] R0,
    output logic [4:0] Result,
    output logic       ResultValid,
    output logic       Busy
`ifdef CALC_ISSUER_STATUS_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0] Level,
    output logic       DropErr
`endif
);
    localparam int M1   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXC = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [5:0]    head_dat;
    logic [AW:0]   fifo_level;
    logic          fifo_empty;
    logic          pop;

    calc_cmd_fifo #(.W(6), .DEPTH(FIFO_DEPTH)) u_fifo (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .push_vld (CmdValid),
        .push_dat ({CmdOP, CmdK, CmdClr}),
        .push_rdy (CmdReady),
        .pop      (pop),
        .pop_dat  (head_dat),
        .level    (fifo_level)
    );

    assign fifo_empty = (fifo_level == '0);
    // A pop happens when idle, or at the end of HOLD for back-to-back issue.
    assign pop  = !fifo_empty && ((state == IDLE) || ((state == HOLD) && (cnt == '0)));
    assign Busy = (state != IDLE) || !fifo_empty;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            Perform     <= 1'b0;
            OP          <= '0;
            K           <= '0;
            Clr         <= 1'b0;
            Result      <= '0;
            ResultValid <= 1'b0;
        end else begin
            ResultValid <= 1'b0;
            if (pop) {OP, K, Clr} <= head_dat;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= SETUP;
                        cnt   <= CW'(SETUP_CYC - 1);
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state   <= PULSE;
                        cnt     <= CW'(PULSE_CYC - 1);
                        Perform <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state   <= HOLD;
                        cnt     <= CW'(HOLD_CYC - 1);
                        Perform <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        Result      <= R0;
                        ResultValid <= 1'b1;
                        if (!fifo_empty) begin
                            state <= SETUP;
                            cnt   <= CW'(SETUP_CYC - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CALC_ISSUER_STATUS_EN
    assign Level = fifo_level;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                     DropErr <= 1'b0;
        else if (CmdValid && !CmdReady) DropErr <= 1'b1;
    end
`endif
endmodule
